// File: rtl/axis_width_downsizer.sv
// AXI-Stream width downsizer: splits IN_WIDTH words into RATIO output beats, LSB slice first.
// Packet framing via pkt_len/tlast, synchronous flush and a running output-beat counter.
module axis_width_downsizer #(
  parameter int unsigned IN_WIDTH  = 128,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 pl_clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  output logic [OUT_WIDTH-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  input  logic [CNT_WIDTH-1:0] pkt_len,
  output logic                 busy,
  output logic [31:0]          beats_out
);

  localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [RATIO-1:0][OUT_WIDTH-1:0] r_buf;
  logic                            r_full;
  logic [IDX_W-1:0]                r_idx;
  logic [CNT_WIDTH-1:0]            r_beat_cnt;
  logic [31:0]                     r_beats_out;

  logic w_last_slice;
  logic w_pkt_end;
  logic w_in_hs;
  logic w_out_hs;

  assign w_last_slice = (r_idx == LAST_IDX);
  assign w_pkt_end    = (pkt_len != '0) && (r_beat_cnt >= pkt_len - CNT_WIDTH'(1));

  // rst is folded in so the upstream sees not-ready for the whole reset window
  assign s_axis_tready = rst && !flush && (!r_full || (m_axis_tready && w_last_slice));
  assign w_in_hs       = s_axis_tvalid && s_axis_tready;
  assign w_out_hs      = r_full && m_axis_tready && !flush;

  generate
    if (RATIO == 1) begin : g_single
      assign m_axis_tdata = r_buf[0];
    end else begin : g_multi
      assign m_axis_tdata = r_buf[r_idx];
    end
  endgenerate

  assign m_axis_tvalid = r_full;
  assign m_axis_tlast  = r_full && w_pkt_end;
  assign busy          = r_full;
  assign beats_out     = r_beats_out;

  always_ff @(posedge pl_clk or negedge rst) begin
    if (!rst) begin
      r_buf       <= '0;
      r_full      <= 1'b0;
      r_idx       <= '0;
      r_beat_cnt  <= '0;
      r_beats_out <= '0;
    end else if (flush) begin
      r_full     <= 1'b0;
      r_idx      <= '0;
      r_beat_cnt <= '0;
    end else begin
      // An accepted word always wins over retiring the last slice on the same edge
      if (w_in_hs) begin
        r_buf  <= s_axis_tdata;
        r_full <= 1'b1;
        r_idx  <= '0;
      end else if (w_out_hs) begin
        if (w_last_slice) begin
          r_idx  <= '0;
          r_full <= 1'b0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end
      if (w_out_hs) begin
        r_beats_out <= r_beats_out + 32'd1;
        r_beat_cnt  <= w_pkt_end ? '0 : r_beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// Directed bench for axis_width_downsizer: default 128->32 instance plus RATIO=1 and RATIO=16
// instances sharing clock, reset, flush, pkt_len and m_axis_tready.
module tb_axis_width_downsizer;

  logic        pl_clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        m_tready = 1'b0;
  logic [15:0] pkt_len = '0;

  logic [127:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tready, m_tvalid, m_tlast, busy;
  logic [31:0]  m_tdata, beats_out;

  logic [127:0] s1_tdata = '0;
  logic         s1_tvalid = 1'b0;
  logic         s1_tready, m1_tvalid, m1_tlast, busy1;
  logic [127:0] m1_tdata;
  logic [31:0]  beats1;

  logic [255:0] s2_tdata = '0;
  logic         s2_tvalid = 1'b0;
  logic         s2_tready, m2_tvalid, m2_tlast, busy2;
  logic [15:0]  m2_tdata;
  logic [31:0]  beats2;

  int tests = 0;
  int fails = 0;
  int exp_beats = 0;

  always #5 pl_clk = ~pl_clk;

  axis_width_downsizer #(.IN_WIDTH(128), .OUT_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .pl_clk(pl_clk), .rst(rst), .flush(flush),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .pkt_len(pkt_len), .busy(busy), .beats_out(beats_out)
  );

  axis_width_downsizer #(.IN_WIDTH(128), .OUT_WIDTH(128), .CNT_WIDTH(16)) u_dut_r1 (
    .pl_clk(pl_clk), .rst(rst), .flush(flush),
    .s_axis_tdata(s1_tdata), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
    .m_axis_tdata(m1_tdata), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m1_tlast), .pkt_len(pkt_len), .busy(busy1), .beats_out(beats1)
  );

  axis_width_downsizer #(.IN_WIDTH(256), .OUT_WIDTH(16), .CNT_WIDTH(16)) u_dut_r16 (
    .pl_clk(pl_clk), .rst(rst), .flush(flush),
    .s_axis_tdata(s2_tdata), .s_axis_tvalid(s2_tvalid), .s_axis_tready(s2_tready),
    .m_axis_tdata(m2_tdata), .m_axis_tvalid(m2_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m2_tlast), .pkt_len(pkt_len), .busy(busy2), .beats_out(beats2)
  );

  // Slice j of word k is 0xA500_kkjj
  function automatic logic [31:0] mk_slice(input int k, input int j);
    return 32'hA500_0000 | (32'(k) << 8) | 32'(j);
  endfunction

  function automatic logic [127:0] mk_word(input int k);
    logic [127:0] w;
    for (int j = 0; j < 4; j++) w[j*32 +: 32] = mk_slice(k, j);
    return w;
  endfunction

  task automatic test_reset();
    @(negedge pl_clk); #1;
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL rst_tready got %b want 0", s_tready); end
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid got %b want 0", m_tvalid); end
    tests++; if (m_tdata !== 32'h0) begin fails++; $display("FAIL rst_tdata got %h want 0", m_tdata); end
    tests++; if (m_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast got %b want 0", m_tlast); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", busy); end
    tests++; if (beats_out !== 32'h0) begin fails++; $display("FAIL rst_beats got %0d want 0", beats_out); end
    @(negedge pl_clk); rst = 1'b1; #1;
    tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL rel_tready got %b want 1", s_tready); end
  endtask

  task automatic test_streaming();
    int wi = 0, n = 0, gaps = 0, cyc = 0;
    int hs[$];
    pkt_len = 16'd0; m_tready = 1'b1;
    while (n < 16 && cyc < 60) begin
      @(negedge pl_clk);
      s_tvalid = (wi < 4); s_tdata = mk_word(wi); #1;
      if (s_tvalid && s_tready) hs.push_back(cyc);
      if (m_tvalid && m_tready) begin
        tests++;
        if (m_tdata !== mk_slice(n / 4, n % 4)) begin
          fails++; $display("FAIL stream_data beat %0d got %h want %h", n, m_tdata, mk_slice(n / 4, n % 4));
        end
        n++;
      end else if (n > 0) gaps++;
      if (s_tvalid && s_tready) wi++;
      cyc++;
    end
    @(negedge pl_clk); s_tvalid = 1'b0; #1;
    exp_beats += 16;
    tests++; if (n != 16) begin fails++; $display("FAIL stream_count got %0d want 16", n); end
    tests++; if (gaps != 0) begin fails++; $display("FAIL stream_gaps got %0d want 0", gaps); end
    tests++;
    if (hs.size() != 4) begin fails++; $display("FAIL stream_hs_count got %0d want 4", hs.size()); end
    else for (int i = 0; i < 4; i++) begin
      tests++;
      if (hs[i] != 4 * i) begin fails++; $display("FAIL stream_hs_cycle %0d got %0d want %0d", i, hs[i], 4 * i); end
    end
    tests++; if (beats_out !== 32'(exp_beats)) begin fails++; $display("FAIL stream_beats got %0d want %0d", beats_out, exp_beats); end
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL stream_drain got %b want 0", m_tvalid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] sb[$];
    logic [31:0] exp_d, prev_d = '0;
    logic prev_stall = 1'b0, prev_v = 1'b0, prev_l = 1'b0, accepted = 1'b0;
    int sent = 0, rcv = 0, cyc = 0;
    pkt_len = 16'd0;
    while (rcv < 4000 && cyc < 30000) begin
      @(negedge pl_clk);
      if (accepted) s_tvalid = 1'b0;
      accepted = 1'b0;
      if (!s_tvalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        s_tvalid = 1'b1; s_tdata = {$urandom, $urandom, $urandom, $urandom};
      end
      m_tready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        tests++;
        if ({m_tvalid, m_tdata, m_tlast} !== {prev_v, prev_d, prev_l}) begin
          fails++; $display("FAIL bp_stable got %b/%h/%b want %b/%h/%b", m_tvalid, m_tdata, m_tlast, prev_v, prev_d, prev_l);
        end
      end
      if (m_tvalid && m_tready) begin
        exp_d = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_DEAD;
        tests++;
        if (m_tdata !== exp_d) begin fails++; $display("FAIL bp_data beat %0d got %h want %h", rcv, m_tdata, exp_d); end
        rcv++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_v = m_tvalid; prev_d = m_tdata; prev_l = m_tlast;
      if (s_tvalid && s_tready) begin
        for (int j = 0; j < 4; j++) sb.push_back(s_tdata[j*32 +: 32]);
        sent++; accepted = 1'b1;
      end
      cyc++;
    end
    @(negedge pl_clk); s_tvalid = 1'b0; m_tready = 1'b1; #1;
    exp_beats += 4000;
    tests++; if (rcv != 4000) begin fails++; $display("FAIL bp_count got %0d want 4000", rcv); end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL bp_leftover got %0d want 0", sb.size()); end
    tests++; if (beats_out !== 32'(exp_beats)) begin fails++; $display("FAIL bp_beats got %0d want %0d", beats_out, exp_beats); end
  endtask

  task automatic test_framing();
    int wi = 0, n = 0, cyc = 0;
    @(negedge pl_clk); flush = 1'b1;
    @(negedge pl_clk); flush = 1'b0;
    pkt_len = 16'd6; m_tready = 1'b1;
    while (n < 12 && cyc < 40) begin
      @(negedge pl_clk);
      s_tvalid = (wi < 3); s_tdata = mk_word(wi + 4); #1;
      if (m_tvalid) begin
        tests++;
        if ({m_tdata, m_tlast} !== {mk_slice(wi + 4 - ((n % 4 == 3) ? 1 : 0) - ((n % 4 == 3) ? 0 : 0), 0) & 32'h0 | mk_slice(n / 4 + 4, n % 4), 1'(n % 6 == 5)}) begin
          fails++; $display("FAIL frame beat %0d got %h/%b want %h/%b", n, m_tdata, m_tlast, mk_slice(n / 4 + 4, n % 4), n % 6 == 5);
        end
        n++;
      end
      if (s_tvalid && s_tready) wi++;
      cyc++;
    end
    @(negedge pl_clk); s_tvalid = 1'b0;
    exp_beats += 12;
    tests++; if (n != 12) begin fails++; $display("FAIL frame_count got %0d want 12", n); end
  endtask

  task automatic test_flush();
    int n = 0, cyc = 0;
    pkt_len = 16'd3; m_tready = 1'b1;
    @(negedge pl_clk); s_tvalid = 1'b1; s_tdata = mk_word(10); #1;
    while (n < 2 && cyc < 10) begin
      @(negedge pl_clk); s_tvalid = 1'b0; #1;
      if (m_tvalid) begin
        tests++;
        if ({m_tdata, m_tlast} !== {mk_slice(10, n), 1'b0}) begin
          fails++; $display("FAIL flush_pre beat %0d got %h/%b want %h/0", n, m_tdata, m_tlast, mk_slice(10, n));
        end
        n++;
      end
      cyc++;
    end
    @(negedge pl_clk); flush = 1'b1; s_tvalid = 1'b1; s_tdata = mk_word(11); #1;
    tests++; if (s_tready !== 1'b0) begin fails++; $display("FAIL flush_tready got %b want 0", s_tready); end
    @(negedge pl_clk); flush = 1'b0; #1;
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL flush_tvalid got %b want 0", m_tvalid); end
    tests++; if (s_tready !== 1'b1) begin fails++; $display("FAIL flush_after_tready got %b want 1", s_tready); end
    n = 0; cyc = 0;
    while (n < 4 && cyc < 10) begin
      @(negedge pl_clk); s_tvalid = 1'b0; #1;
      if (m_tvalid) begin
        tests++;
        if ({m_tdata, m_tlast} !== {mk_slice(11, n), 1'(n == 2)}) begin
          fails++; $display("FAIL flush_post beat %0d got %h/%b want %h/%b", n, m_tdata, m_tlast, mk_slice(11, n), n == 2);
        end
        n++;
      end
      cyc++;
    end
    @(negedge pl_clk); #1;
    exp_beats += 6;
    tests++; if (n != 4) begin fails++; $display("FAIL flush_count got %0d want 4", n); end
    tests++; if (beats_out !== 32'(exp_beats)) begin fails++; $display("FAIL flush_beats got %0d want %0d", beats_out, exp_beats); end
  endtask

  task automatic test_reset_mid();
    int n = 0, cyc = 0;
    pkt_len = 16'd1; m_tready = 1'b0;
    @(negedge pl_clk); s_tvalid = 1'b1; s_tdata = mk_word(20);
    @(negedge pl_clk); s_tvalid = 1'b0; #1;
    tests++; if ({m_tvalid, m_tlast} !== 2'b11) begin fails++; $display("FAIL rmid_pre got %b%b want 11", m_tvalid, m_tlast); end
    #2 rst = 1'b0; #1;
    tests++;
    if ({m_tvalid, m_tlast, busy, s_tready} !== 4'b0000) begin
      fails++; $display("FAIL rmid_flags got %b%b%b%b want 0000", m_tvalid, m_tlast, busy, s_tready);
    end
    tests++; if (beats_out !== 32'h0) begin fails++; $display("FAIL rmid_beats got %0d want 0", beats_out); end
    @(negedge pl_clk); rst = 1'b1; pkt_len = 16'd0; m_tready = 1'b1; #1;
    tests++; if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rmid_release got %b want 0", m_tvalid); end
    @(negedge pl_clk); s_tvalid = 1'b1; s_tdata = mk_word(21);
    while (n < 4 && cyc < 10) begin
      @(negedge pl_clk); s_tvalid = 1'b0; #1;
      if (m_tvalid) begin
        tests++;
        if (m_tdata !== mk_slice(21, n)) begin fails++; $display("FAIL rmid_data beat %0d got %h want %h", n, m_tdata, mk_slice(21, n)); end
        n++;
      end
      cyc++;
    end
    @(negedge pl_clk); #1;
    tests++; if (beats_out !== 32'd4) begin fails++; $display("FAIL rmid_beats_after got %0d want 4", beats_out); end
  endtask

  task automatic test_ratio1();
    int wi = 0, n = 0, cyc = 0, bubbles = 0;
    logic [127:0] exp_w;
    pkt_len = 16'd2; m_tready = 1'b1;
    while (n < 3 && cyc < 20) begin
      @(negedge pl_clk);
      s1_tvalid = (wi < 3); s1_tdata = {32'(wi), 32'hC0DE_0000, 32'hB1B1_B1B1, 32'(wi + 7)}; #1;
      if (s1_tvalid && !s1_tready) bubbles++;
      if (m1_tvalid) begin
        exp_w = {32'(n), 32'hC0DE_0000, 32'hB1B1_B1B1, 32'(n + 7)};
        tests++;
        if ({m1_tdata, m1_tlast} !== {exp_w, 1'(n % 2 == 1)}) begin
          fails++; $display("FAIL r1_beat %0d got %h/%b want %h/%b", n, m1_tdata, m1_tlast, exp_w, n % 2 == 1);
        end
        n++;
      end
      if (s1_tvalid && s1_tready) wi++;
      cyc++;
    end
    @(negedge pl_clk); s1_tvalid = 1'b0; #1;
    tests++; if (n != 3) begin fails++; $display("FAIL r1_count got %0d want 3", n); end
    tests++; if (bubbles != 0) begin fails++; $display("FAIL r1_bubbles got %0d want 0", bubbles); end
    tests++; if ({beats1, busy1} !== {32'd3, 1'b0}) begin fails++; $display("FAIL r1_beats got %0d/%b want 3/0", beats1, busy1); end
  endtask

  task automatic test_ratio16();
    int wi = 0, n = 0, cyc = 0, hs1 = -1;
    logic [255:0] w;
    logic [15:0] exp_d;
    pkt_len = 16'd5; m_tready = 1'b1;
    while (n < 32 && cyc < 60) begin
      @(negedge pl_clk);
      for (int j = 0; j < 16; j++) w[j*16 +: 16] = 16'(((wi + 1) << 8) | j);
      s2_tvalid = (wi < 2); s2_tdata = w; #1;
      if (s2_tvalid && s2_tready && wi == 1) hs1 = cyc;
      if (m2_tvalid) begin
        exp_d = 16'(((n / 16 + 1) << 8) | (n % 16));
        tests++;
        if ({m2_tdata, m2_tlast} !== {exp_d, 1'(n % 5 == 4)}) begin
          fails++; $display("FAIL r16_beat %0d got %h/%b want %h/%b", n, m2_tdata, m2_tlast, exp_d, n % 5 == 4);
        end
        n++;
      end
      if (s2_tvalid && s2_tready) wi++;
      cyc++;
    end
    @(negedge pl_clk); s2_tvalid = 1'b0; #1;
    tests++; if (n != 32) begin fails++; $display("FAIL r16_count got %0d want 32", n); end
    tests++; if (hs1 != 16) begin fails++; $display("FAIL r16_hs_cycle got %0d want 16", hs1); end
    tests++; if (beats2 !== 32'd32) begin fails++; $display("FAIL r16_beats got %0d want 32", beats2); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_framing();
    test_flush();
    test_reset_mid();
    test_ratio1();
    test_ratio16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
